div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
//  Multi-cycle radix-2 restoring divider with its sequencing FSM. Serves the
//  EX-stage start/ready handshake: EX holds div_start = !div_ready (and stalls)
//  until this block pulses div_ready with {remainder, quotient} for HI/LO.
//  Sits beside the EX ALU; one divide in flight; flushes cancel it.
// PARAMETERS
//  WIDTH      32  operand width; result is 2*WIDTH bits
//  ZERO_FAST  1   1: divide-by-zero finishes without iterating
// PORTS
//  clk         in   1        clock (rising edge)
//  resetn      in   1        asynchronous active-low reset
//  div_start   in   1        request; level, held high by EX until div_ready
//  div_signed  in   1        1: signed (DIV), 0: unsigned (DIVU); sampled w/ start
//  div_cancel  in   1        pipeline flush/exception; aborts current divide
//  opr1        in   WIDTH    dividend, sampled on accepted start
//  opr2        in   WIDTH    divisor, sampled on accepted start
//  div_ready   out  1        one-cycle pulse: div_res valid this cycle
//  div_busy    out  1        high in BUSY/DONE
//  div_res     out  2*WIDTH  {remainder, quotient}; held until next accept
// BEHAVIOUR
//  Reset (resetn=0, async): state IDLE, count 0, div_ready 0, div_busy 0,
//   div_res 0, internal operand/sign regs 0.
//  States: IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: div_start & !div_cancel accepted: latch |opr1|,|opr2| (abs only if
//   div_signed), quotient sign = s1^s2 (signed only), remainder sign = s1;
//   clear partial remainder; count=0; go BUSY. Else stay.
//  BUSY: one restoring step per cycle: shift {rem,dvd} left 1; if rem>=dvs
//   then rem-=dvs, quotient bit=1. count++; after WIDTH steps go DONE.
//   ZERO_FAST=1 and divisor==0: go DONE on first BUSY cycle.
//  DONE: div_ready=1 for exactly this cycle; div_res = sign-fixed
//   {rem, quo} (two's-complement negate where sign bit set); next IDLE.
//  Latency: start first seen in IDLE at cycle T -> div_ready at T+WIDTH+2
//   (T+2 on fast zero path). EX drops start the cycle ready is high, so
//   DONE->IDLE never re-accepts the same instruction.
//  Divide by zero: quotient = all ones, remainder = dividend (original, with
//   sign); applies both ZERO_FAST settings; no exception raised.
//  Overflow 0x80000000 / -1 signed: quotient 0x80000000, remainder 0.
//  div_cancel: highest priority in every state; next state IDLE, div_ready
//   not pulsed that cycle nor later, div_res unchanged. Cancel in the same
//   cycle as start in IDLE: start ignored.
//  div_start while BUSY/DONE ignored (operands not re-sampled).
//  Internal width: partial remainder WIDTH+1 bits; count $clog2(WIDTH+1).
// TESTING
//  DIVU 100/7: start held -> div_ready at T+34, div_res={32'd2, 32'd14}.
//  DIV -7/2 signed: div_res={32'hFFFFFFFF, 32'hFFFFFFFD} (rem -1, quo -3).
//  DIV 0x80000000/0xFFFFFFFF: div_res={32'h0, 32'h80000000}; DIVU 5/0:
//   ready at T+2, div_res={32'd5, 32'hFFFFFFFF}.
//  div_cancel at BUSY count 10 -> IDLE next cycle, no ready, div_res held;
//   new start 9/3 afterwards -> {0, 3} with full latency.
//  resetn low mid-BUSY -> all outputs 0 immediately; ready absent after release.
//  Back-to-back DIVs with start dropped on ready: each accepted once, 2 pulses.

Source files
------------

// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider with its sequencing FSM.
// EX keeps div_start high, and stalls, until div_ready pulses. One divide is
// in flight at a time, and div_cancel (flush) aborts it.
// Ports:
//   clk, resetn            clock (rising edge), asynchronous active-low reset
//   div_start              request level, held by EX until div_ready
//   div_signed             1: DIV (signed), 0: DIVU; sampled with start
//   div_cancel             flush; wins over everything in every state
//   opr1, opr2             dividend / divisor, sampled on accepted start
//   div_ready              one-cycle pulse, div_res valid this cycle
//   div_busy               high while in BUSY or DONE
//   div_res                {remainder, quotient}; held until the next result
module div_seq #(
  parameter int WIDTH     = 32,
  parameter bit ZERO_FAST = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               div_start,
  input  logic               div_signed,
  input  logic               div_cancel,
  input  logic [WIDTH-1:0]   opr1,
  input  logic [WIDTH-1:0]   opr2,
  output logic               div_ready,
  output logic               div_busy,
  output logic [2*WIDTH-1:0] div_res
);
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   dvd_q;   // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   rem_q;
  logic               qneg_q, rneg_q;
  logic [2*WIDTH-1:0] res_q;

  logic               s1, s2;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     sh, diff;
  logic               ge, dvs_zero;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    s1       = div_signed & opr1[WIDTH-1];
    s2       = div_signed & opr2[WIDTH-1];
    abs1     = s1 ? (~opr1 + 1'b1) : opr1;
    abs2     = s2 ? (~opr2 + 1'b1) : opr2;
    // Partial remainder is WIDTH+1 wide; the borrow out of the trial
    // subtract is the compare result.
    sh       = {rem_q, dvd_q[WIDTH-1]};
    diff     = sh - {1'b0, dvs_q};
    ge       = ~diff[WIDTH];
    dvs_zero = (dvs_q == '0);
    // Divide by zero: the iteration already leaves |dividend| in rem_q, so
    // only the quotient needs forcing (the sign fix would otherwise spoil it).
    quo_fix  = dvs_zero ? '1 : (qneg_q ? (~dvd_q + 1'b1) : dvd_q);
    rem_fix  = rneg_q ? (~rem_q + 1'b1) : rem_q;
  end

  // Ready and the fresh result are gated by cancel in the DONE cycle itself,
  // so a flush landing on DONE neither pulses ready nor disturbs div_res.
  assign div_ready = (state_q == S_DONE) & ~div_cancel;
  assign div_busy  = (state_q != S_IDLE);
  assign div_res   = div_ready ? {rem_fix, quo_fix} : res_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
    end else if (div_cancel) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (div_start) begin
          dvd_q   <= abs1;
          dvs_q   <= abs2;
          rem_q   <= '0;
          cnt_q   <= '0;
          qneg_q  <= s1 ^ s2;
          rneg_q  <= s1;
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          if (cnt_q == CW'(WIDTH)) begin
            state_q <= S_DONE;
          end else if (ZERO_FAST && dvs_zero) begin
            rem_q   <= dvd_q;
            dvd_q   <= '1;
            state_q <= S_DONE;
          end else begin
            rem_q <= ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
            dvd_q <= {dvd_q[WIDTH-2:0], ge};
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          res_q   <= {rem_fix, quo_fix};
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;
  logic        clk, resetn;
  logic        div_start, div_signed, div_cancel;
  logic [31:0] opr1, opr2;
  logic        div_ready, div_busy;
  logic [63:0] div_res;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  div_seq #(.WIDTH(32), .ZERO_FAST(1'b1)) dut (
    .clk(clk), .resetn(resetn), .div_start(div_start), .div_signed(div_signed),
    .div_cancel(div_cancel), .opr1(opr1), .opr2(opr2), .div_ready(div_ready),
    .div_busy(div_busy), .div_res(div_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (div_ready) pulses++;

  typedef struct {
    logic        sgn;
    logic [31:0] a, b;
    logic [63:0] res;
    int          lat;
  } vec_t;
  vec_t v[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns in the ready cycle with start dropped.
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] r, output int lat);
    div_start = 1'b1; div_signed = s; opr1 = a; opr2 = b;
    lat = -1; r = '0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin opr1 = 32'hDEADBEEF; opr2 = 32'h00001234; div_signed = ~s; end
      if (div_ready) begin lat = n; r = div_res; break; end
    end
    div_start = 1'b0;
  endtask

  logic [63:0] r, held;
  int          lat, p0;

  initial begin
    v[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 34};
    v[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},    34};
    v[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h0, 32'h80000000},           34};
    v[3]  = '{1'b0, 32'd5,          32'd0,          {32'd5, 32'hFFFFFFFF},           2};
    v[4]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          {32'hFFFFFFFB, 32'hFFFFFFFF},    2};
    v[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'h0, 32'hFFFFFFFF},           34};
    v[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},           34};
    v[7]  = '{1'b0, 32'd0,          32'd9,          {32'd0, 32'd0},                  34};
    v[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'd14},          34};
    v[9]  = '{1'b0, 32'h12345678,   32'd1000,       {32'h380, 32'h0004A90B},         34};
    v[10] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'h0},           34};

    resetn = 1'b0; div_start = 1'b0; div_signed = 1'b0; div_cancel = 1'b0;
    opr1 = '0; opr2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(div_ready), 64'd0);
    chk("rst_busy",  64'(div_busy),  64'd0);
    chk("rst_res",   div_res,        64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      do_div(v[i].sgn, v[i].a, v[i].b, r, lat);
      chk($sformatf("lat%0d", i), 64'(lat), 64'(v[i].lat));
      chk($sformatf("res%0d", i), r, v[i].res);
      @(posedge clk); #1;
      chk($sformatf("pulse%0d", i), 64'(div_ready), 64'd0);
      chk($sformatf("held%0d", i), div_res, v[i].res);
    end
    held = v[10].res;

    // Cancel at BUSY count 10.
    p0 = pulses;
    div_start = 1'b1; div_signed = 1'b0; opr1 = 32'd100; opr2 = 32'd7;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    chk("cnc_busy_before", 64'(div_busy), 64'd1);
    div_cancel = 1'b1; div_start = 1'b0;
    @(posedge clk); #1;
    div_cancel = 1'b0;
    chk("cnc_idle", 64'(div_busy), 64'd0);
    chk("cnc_res_held", div_res, held);
    repeat (40) @(posedge clk);
    #1;
    chk("cnc_no_ready", 64'(pulses - p0), 64'd0);
    do_div(1'b0, 32'd9, 32'd3, r, lat);
    chk("after_cnc_lat", 64'(lat), 64'd34);
    chk("after_cnc_res", r, {32'd0, 32'd3});
    @(posedge clk); #1;
    held = {32'd0, 32'd3};

    // Cancel landing on the DONE cycle.
    p0 = pulses;
    div_start = 1'b1; div_signed = 1'b0; opr1 = 32'd100; opr2 = 32'd7;
    repeat (34) @(posedge clk);
    #1;
    div_cancel = 1'b1; div_start = 1'b0;
    #1;
    chk("cnc_done_ready", 64'(div_ready), 64'd0);
    chk("cnc_done_res", div_res, held);
    @(posedge clk); #1;
    div_cancel = 1'b0;
    chk("cnc_done_idle", 64'(div_busy), 64'd0);
    chk("cnc_done_res2", div_res, held);
    chk("cnc_done_pulses", 64'(pulses - p0), 64'd0);

    // Cancel together with start in IDLE.
    div_start = 1'b1; div_cancel = 1'b1; opr1 = 32'd50; opr2 = 32'd5;
    @(posedge clk); #1;
    chk("cnc_start_busy", 64'(div_busy), 64'd0);
    div_start = 1'b0; div_cancel = 1'b0;
    @(posedge clk); #1;

    // Reset mid-BUSY.
    div_start = 1'b1; opr1 = 32'd100; opr2 = 32'd7;
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("rstb_ready", 64'(div_ready), 64'd0);
    chk("rstb_busy",  64'(div_busy),  64'd0);
    chk("rstb_res",   div_res,        64'd0);
    div_start = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    p0 = pulses;
    repeat (40) @(posedge clk);
    #1;
    chk("rstb_no_ready", 64'(pulses - p0), 64'd0);
    chk("rstb_idle", 64'(div_busy), 64'd0);

    // Back-to-back divides, start dropped on ready.
    p0 = pulses;
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, r, lat);
    chk("b2b_res0", r, {32'hFFFFFFFF, 32'hFFFFFFFD});
    @(posedge clk); #1;
    do_div(1'b0, 32'd100, 32'd7, r, lat);
    chk("b2b_lat1", 64'(lat), 64'd34);
    chk("b2b_res1", r, {32'd2, 32'd14});
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_pulses", 64'(pulses - p0), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end
endmodule
